// File: rtl/priority_codec_pkg.sv
// Shared definitions for the priority encoder/decoder pair.
// Entry layout is {none, idx}, matching the encoder output side.
package priority_codec_pkg;

    localparam int PC_IDX_W = 2;

    function automatic int oh_w(input int idx_w);
        return 1 << idx_w;
    endfunction

    function automatic int ent_w(input int idx_w);
        return idx_w + 1;
    endfunction

    typedef struct packed {
        logic                none;
        logic [PC_IDX_W-1:0] idx;
    } pc_entry_t;

endpackage

// File: rtl/pd_sync_fifo.sv
// Small synchronous FIFO with binary pointers one bit wider
// than the address; full/empty come from the MSB compare.
module pd_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [W-1:0]  mem [DEPTH];

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    // Pointer and storage update; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + PW'(1);
            end
            if (pop && !empty) begin
                rp <= rp + PW'(1);
            end
        end
    end

endmodule

// File: rtl/priority_decoder_stream.sv
// Streaming index-to-one-hot decoder with FIFO buffering,
// bypass into a registered output and an acceptance counter.
module priority_decoder_stream
    import priority_codec_pkg::*;
#(
    parameter int IDX_W   = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    localparam int OH_W   = oh_w(IDX_W),
    localparam int ENT_W  = ent_w(IDX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OH_W-1:0]  out_onehot,
    output logic             out_none,
    output logic [CNT_W-1:0] acc_count
);

    logic             run_q;
    logic             ov_q;
    logic [OH_W-1:0]  oh_q;
    logic             none_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ENT_W-1:0] entry_in;
    logic [ENT_W-1:0] fifo_dout;
    logic [ENT_W-1:0] src;
    logic [OH_W-1:0]  dec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             can_load;
    logic             load;
    logic             push;
    logic             pop;

    assign entry_in = {in_none, in_idx};

    // run_q keeps in_ready low until the first edge after reset.
    assign in_ready = en & run_q & ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign can_load = en & (~ov_q | out_ready);
    assign load     = can_load & (~fifo_empty | accept);
    assign pop      = load & ~fifo_empty;
    assign push     = accept & ~(load & fifo_empty);

    assign out_valid  = en & ov_q;
    assign out_onehot = oh_q;
    assign out_none   = none_q;
    assign acc_count  = cnt_q;

    pd_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Select FIFO head, or bypass the incoming entry, then decode.
    always_comb begin
        src = fifo_empty ? entry_in : fifo_dout;
        dec = '0;
        if (!src[IDX_W]) begin
            dec = OH_W'(1) << src[IDX_W-1:0];
        end
    end

    // Release gate for in_ready after reset deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Output register: load a new word or retire the taken one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            oh_q   <= '0;
            none_q <= 1'b0;
        end else if (load) begin
            ov_q   <= 1'b1;
            oh_q   <= dec;
            none_q <= src[IDX_W];
        end else if (en && ov_q && out_ready) begin
            ov_q   <= 1'b0;
        end
    end

    // Accepted-entry counter, wraps modulo 2**CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
